// File: rtl/nand_wr.sv
// NAND write-cycle strobe generator: one CLE/ALE/data latch cycle per Start.
// Optional multi-byte data bursts when NAND_WR_BURST_EN is defined.
`timescale 1ns/1ps
module nand_wr #(
  parameter int unsigned tSETUP_cnt = 1,
  parameter int unsigned tWP_cnt    = 2,
  parameter int unsigned tHOLD_cnt  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [1:0] Cycle_Type,
  input  logic [7:0] Din,
`ifdef NAND_WR_BURST_EN
  input  logic [7:0] Len,
  output logic       Din_Req,
`endif
  output logic       Over,
  output logic       Busy,
  output logic       Err,
  output logic       CLE,
  output logic       ALE,
  output logic       WEn,
  output logic [7:0] DQ_Out,
  output logic       DQ_OE
);

  localparam int unsigned CNT_W = 8;
  // Last count value of each timed phase; a zero count behaves as one cycle.
  localparam logic [CNT_W-1:0] SETUP_LAST = (tSETUP_cnt == 0) ? '0 : CNT_W'(tSETUP_cnt - 1);
  localparam logic [CNT_W-1:0] WP_LAST    = (tWP_cnt == 0)    ? '0 : CNT_W'(tWP_cnt - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = (tHOLD_cnt == 0)  ? '0 : CNT_W'(tHOLD_cnt - 1);

  typedef enum logic [2:0] {IDLE, SETUP, WE_LOW, HOLD, OVER} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
`ifdef NAND_WR_BURST_EN
  logic [7:0]       rem;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      WEn    <= 1'b1;
      CLE    <= 1'b0;
      ALE    <= 1'b0;
      DQ_OE  <= 1'b0;
      DQ_Out <= '0;
      Over   <= 1'b0;
      Busy   <= 1'b0;
      Err    <= 1'b0;
`ifdef NAND_WR_BURST_EN
      rem     <= '0;
      Din_Req <= 1'b0;
`endif
    end else begin
      Over <= 1'b0;
      Err  <= 1'b0;
`ifdef NAND_WR_BURST_EN
      Din_Req <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start) begin
            cnt  <= '0;
            Busy <= 1'b1;
`ifdef NAND_WR_BURST_EN
            rem <= (Cycle_Type == 2'b10 && Len > 8'd1) ? Len - 8'd1 : '0;
`endif
            if (Cycle_Type == 2'b11) begin
              // Reserved type: report and finish without touching the bus.
              state <= OVER;
              Over  <= 1'b1;
              Err   <= 1'b1;
            end else begin
              state  <= SETUP;
              DQ_OE  <= 1'b1;
              DQ_Out <= Din;
              CLE    <= (Cycle_Type == 2'b00);
              ALE    <= (Cycle_Type == 2'b01);
            end
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= WE_LOW;
            cnt   <= '0;
            WEn   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WE_LOW: begin
          if (cnt == WP_LAST) begin
            state <= HOLD;
            cnt   <= '0;
            WEn   <= 1'b1;
`ifdef NAND_WR_BURST_EN
            Din_Req <= (HOLD_LAST == '0) && (rem != '0);
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
`ifdef NAND_WR_BURST_EN
            // More bytes pending: the requester has placed the next byte on Din.
            if (rem != '0) begin
              state  <= SETUP;
              rem    <= rem - 8'd1;
              DQ_Out <= Din;
            end else
`endif
            begin
              state <= OVER;
              Over  <= 1'b1;
              CLE   <= 1'b0;
              ALE   <= 1'b0;
              DQ_OE <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
`ifdef NAND_WR_BURST_EN
            Din_Req <= ((cnt + CNT_W'(1)) == HOLD_LAST) && (rem != '0);
`endif
          end
        end
        OVER: begin
          state  <= IDLE;
          cnt    <= '0;
          Busy   <= 1'b0;
          DQ_Out <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_wr.sv
// Scoreboard bench for nand_wr: a monitor summarises each write cycle on Over,
// and tasks compare that summary with a timeline model pushed at stimulus time.
`timescale 1ns/1ps
module tb_nand_wr;

  typedef struct packed {
    logic [15:0] over_cyc;
    logic [15:0] we_fall;
    logic [7:0]  we_low;
    logic [7:0]  pulses;
    logic [7:0]  cle_cnt;
    logic [7:0]  ale_cnt;
    logic [7:0]  busy_cnt;
    logic [7:0]  req_cnt;
    logic [7:0]  dq_chg;
    logic [31:0] dq_seq;
    logic        oe_any;
    logic        err;
    logic        bad;
  } rec_t;

  localparam int TS0 = 1, TW0 = 2, TH0 = 1;
  localparam int TS1 = 2, TW1 = 3, TH1 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start  [2];
  logic [1:0] ctype  [2];
  logic [7:0] din    [2];
  logic       over   [2];
  logic       busy   [2];
  logic       err    [2];
  logic       cle    [2];
  logic       ale    [2];
  logic       wen    [2];
  logic [7:0] dq_out [2];
  logic       dq_oe  [2];
`ifdef NAND_WR_BURST_EN
  logic [7:0] len     [2];
  logic       din_req [2];
`endif

  int   cyc;
  int   checks;
  int   errors;
  rec_t exp0[$], exp1[$], obs0[$], obs1[$];
  rec_t acc [2];
  logic prev_wen [2];
  logic prev_oe  [2];
  logic [7:0] prev_dq [2];

  nand_wr #(.tSETUP_cnt(TS0), .tWP_cnt(TW0), .tHOLD_cnt(TH0)) u_dut0 (
    .CLK(clk), .RST(rst), .Start(start[0]), .Cycle_Type(ctype[0]), .Din(din[0]),
`ifdef NAND_WR_BURST_EN
    .Len(len[0]), .Din_Req(din_req[0]),
`endif
    .Over(over[0]), .Busy(busy[0]), .Err(err[0]), .CLE(cle[0]), .ALE(ale[0]),
    .WEn(wen[0]), .DQ_Out(dq_out[0]), .DQ_OE(dq_oe[0])
  );

  nand_wr #(.tSETUP_cnt(TS1), .tWP_cnt(TW1), .tHOLD_cnt(TH1)) u_dut1 (
    .CLK(clk), .RST(rst), .Start(start[1]), .Cycle_Type(ctype[1]), .Din(din[1]),
`ifdef NAND_WR_BURST_EN
    .Len(len[1]), .Din_Req(din_req[1]),
`endif
    .Over(over[1]), .Busy(busy[1]), .Err(err[1]), .CLE(cle[1]), .ALE(ale[1]),
    .WEn(wen[1]), .DQ_Out(dq_out[1]), .DQ_OE(dq_oe[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Fold one sampled cycle of DUT i into its running transaction summary.
  function automatic rec_t upd(input int i);
    rec_t r;
    r = acc[i];
    if (wen[i] === 1'b0) begin
      r.we_low = r.we_low + 8'd1;
      if (prev_wen[i] === 1'b1) begin
        r.pulses = r.pulses + 8'd1;
        r.dq_seq = {r.dq_seq[23:0], dq_out[i]};
        if (r.we_fall == 16'd0) r.we_fall = 16'(cyc);
      end
    end
    if (cle[i] === 1'b1) r.cle_cnt = r.cle_cnt + 8'd1;
    if (ale[i] === 1'b1) r.ale_cnt = r.ale_cnt + 8'd1;
    if (busy[i] === 1'b1) r.busy_cnt = r.busy_cnt + 8'd1;
`ifdef NAND_WR_BURST_EN
    if (din_req[i] === 1'b1) r.req_cnt = r.req_cnt + 8'd1;
`endif
    if (dq_oe[i] === 1'b1) r.oe_any = 1'b1;
    if (dq_oe[i] === 1'b1 && prev_oe[i] === 1'b1 && dq_out[i] !== prev_dq[i])
      r.dq_chg = r.dq_chg + 8'd1;
    if ((cle[i] === 1'b1 && ale[i] === 1'b1) || (wen[i] === 1'b0 && dq_oe[i] !== 1'b1))
      r.bad = 1'b1;
    if (over[i] === 1'b1) begin
      r.over_cyc = 16'(cyc);
      r.err      = err[i];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst === 1'b1) begin
        acc[i]      <= '0;
        prev_wen[i] <= 1'b1;
        prev_oe[i]  <= 1'b0;
        prev_dq[i]  <= '0;
      end else begin
        if (over[i] === 1'b1) begin
          if (i == 0) obs0.push_back(upd(i));
          else        obs1.push_back(upd(i));
          acc[i] <= '0;
        end else begin
          acc[i] <= upd(i);
        end
        prev_wen[i] <= wen[i];
        prev_oe[i]  <= dq_oe[i];
        prev_dq[i]  <= dq_out[i];
      end
    end
  end

  // Expected summary of a single-byte cycle started at edge e0.
  function automatic rec_t model(input logic [1:0] t, input logic [7:0] d,
                                 input int ts, input int twp, input int th, input int e0);
    rec_t r;
    int   tot;
    r   = '0;
    tot = ts + twp + th;
    if (t == 2'b11) begin
      r.over_cyc = 16'(e0);
      r.busy_cnt = 8'd1;
      r.err      = 1'b1;
    end else begin
      r.over_cyc = 16'(e0 + tot);
      r.we_fall  = 16'(e0 + ts);
      r.we_low   = 8'(twp);
      r.pulses   = 8'd1;
      r.cle_cnt  = (t == 2'b00) ? 8'(tot) : 8'd0;
      r.ale_cnt  = (t == 2'b01) ? 8'(tot) : 8'd0;
      r.busy_cnt = 8'(tot + 1);
      r.dq_seq   = {24'h0, d};
      r.oe_any   = 1'b1;
    end
    return r;
  endfunction

  task automatic issue(input int i, input logic [1:0] t, input logic [7:0] d, output int e0);
    @(posedge clk); #2;
    start[i] = 1'b1;
    ctype[i] = t;
    din[i]   = d;
    e0       = cyc + 1;
    @(posedge clk); #2;
    start[i] = 1'b0;
    ctype[i] = 2'b11;
    din[i]   = 8'hEE;
  endtask

  task automatic wait_obs(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (((i == 0) ? obs0.size() : obs1.size()) > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] o;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = {wen[i], cle[i], ale[i], dq_oe[i], dq_out[i], over[i], busy[i], err[i]};
      checks++;
      if (o !== 15'h4000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h expected %h", i, o, 15'h4000);
      end
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_command();
    int e0;
    bit ok;
    rec_t e, o;
    issue(0, 2'b00, 8'h80, e0);
    exp0.push_back(model(2'b00, 8'h80, TS0, TW0, TH0, e0));
    wait_obs(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL command: no Over within budget, expected at cycle %0d", e0 + 4);
    end else begin
      e = exp0.pop_front();
      o = obs0.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL command: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_address();
    int e0;
    bit ok;
    rec_t e, o;
    repeat (2) @(posedge clk);
    issue(1, 2'b01, 8'h3C, e0);
    exp1.push_back(model(2'b01, 8'h3C, TS1, TW1, TH1, e0));
    wait_obs(1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL address: no Over within budget, expected at cycle %0d", e0 + 7);
    end else begin
      e = exp1.pop_front();
      o = obs1.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL address: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_reserved();
    int e0;
    bit ok;
    rec_t e, o;
    for (int i = 0; i < 2; i++) begin
      repeat (2) @(posedge clk);
      issue(i, 2'b11, 8'h5A, e0);
      if (i == 0) exp0.push_back(model(2'b11, 8'h5A, TS0, TW0, TH0, e0));
      else        exp1.push_back(model(2'b11, 8'h5A, TS1, TW1, TH1, e0));
      wait_obs(i, 20, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL reserved dut%0d: no Over within budget", i);
      end else begin
        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
        o = (i == 0) ? obs0.pop_front() : obs1.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reserved dut%0d: got %h expected %h", i, o, e);
        end
      end
    end
  endtask

  task automatic test_data();
    int e0;
    bit ok;
    rec_t e, o;
    repeat (2) @(posedge clk);
    issue(1, 2'b10, 8'hA5, e0);
    exp1.push_back(model(2'b10, 8'hA5, TS1, TW1, TH1, e0));
    wait_obs(1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL data: no Over within budget");
    end else begin
      e = exp1.pop_front();
      o = obs1.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL data: got %h expected %h", o, e);
      end
    end
  endtask

  // Start held high: a new cycle every 6 edges, junk on Din between samples.
  task automatic test_back_to_back();
    int e0;
    bit ok;
    rec_t e, o;
    logic [7:0] b [4];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
    repeat (2) @(posedge clk);
    #2;
    e0       = cyc + 1;
    start[0] = 1'b1;
    ctype[0] = 2'b10;
    for (int j = 0; j < 24; j++) begin
      if (j % 6 == 0) begin
        din[0] = b[j / 6];
        exp0.push_back(model(2'b10, b[j / 6], TS0, TW0, TH0, e0 + j));
      end else begin
        din[0] = 8'($urandom);
      end
      @(posedge clk); #2;
    end
    start[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_obs(0, 30, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL back_to_back[%0d]: no Over within budget", k);
      end else begin
        e = exp0.pop_front();
        o = obs0.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", k, o, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    bit ok;
    rec_t e, o;
    logic [3:0] s;
    repeat (2) @(posedge clk);
    issue(0, 2'b00, 8'h96, e0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = {wen[0], dq_oe[0], busy[0], over[0]};
    checks++;
    if (s !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got WEn/OE/Busy/Over=%b expected 1000", s);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    checks++;
    if (obs0.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_no_over: got %0d Over events expected 0", obs0.size());
      obs0.delete();
    end
    issue(0, 2'b01, 8'hC3, e0);
    exp0.push_back(model(2'b01, 8'hC3, TS0, TW0, TH0, e0));
    wait_obs(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_mid_restart: no Over within budget");
    end else begin
      e = exp0.pop_front();
      o = obs0.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_restart: got %h expected %h", o, e);
      end
    end
  endtask

`ifdef NAND_WR_BURST_EN
  task automatic test_burst();
    int e0;
    int nb;
    bit ok;
    rec_t e, o;
    logic [7:0] bs [3];
    bs[0] = 8'hA1; bs[1] = 8'hA2; bs[2] = 8'hA3;
    repeat (2) @(posedge clk);
    len[0] = 8'd3;
    issue(0, 2'b10, bs[0], e0);
    len[0] = 8'd0;
    e = '0;
    e.over_cyc = 16'(e0 + 12);
    e.we_fall  = 16'(e0 + 1);
    e.we_low   = 8'd6;
    e.pulses   = 8'd3;
    e.busy_cnt = 8'd13;
    e.req_cnt  = 8'd2;
    e.dq_chg   = 8'd2;
    e.dq_seq   = {8'h00, 8'hA1, 8'hA2, 8'hA3};
    e.oe_any   = 1'b1;
    exp0.push_back(e);
    nb = 1;
    for (int k = 0; k < 30 && obs0.size() == 0; k++) begin
      if (din_req[0] === 1'b1 && nb < 3) begin
        din[0] = bs[nb];
        nb++;
      end
      @(posedge clk); #2;
    end
    wait_obs(0, 5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL burst: no Over within budget");
    end else begin
      e = exp0.pop_front();
      o = obs0.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL burst: got %h expected %h", o, e);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      ctype[i] = 2'b00;
      din[i]   = 8'h00;
`ifdef NAND_WR_BURST_EN
      len[i]   = 8'd0;
`endif
    end
    checks = 0;
    errors = 0;
    test_reset();
    test_command();
    test_address();
    test_reserved();
    test_data();
    test_back_to_back();
    test_reset_mid();
`ifdef NAND_WR_BURST_EN
    test_burst();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 50000 ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nand_wr.md
Name: nand_wr

Overview:
- Write-cycle strobe generator for the NAND bridge; the transmit-side counterpart of the read-cycle generator.
- On a Start request it issues one NAND latch cycle: command (CLE), address (ALE) or data byte. It drives DQ and pulses WEn with programmable setup, pulse-width and hold counts.
- It sits between the bridge sequencer (which sequences command/address/data phases) and the NAND pads; DQ tristate is resolved at top level using DQ_OE.

Parameters:
- tSETUP_cnt, 1, CLK cycles CLE/ALE/DQ are valid with WEn high before the WEn falling edge (tCLS/tALS/tDS); 0 treated as 1.
- tWP_cnt, 2, CLK cycles WEn is held low (tWP); 0 treated as 1.
- tHOLD_cnt, 1, CLK cycles CLE/ALE/DQ are held after WEn rises (tCLH/tALH/tDH, tWH); 0 treated as 1.

Ports:
- CLK  in  1  bridge clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- Start  in  1  request; sampled only in IDLE.
- Cycle_Type  in  2  00 command, 01 address, 10 data, 11 reserved; sampled with Start.
- Din  in  8  byte to write; sampled with Start.
- Over  out  1  one-cycle completion pulse.
- Busy  out  1  high in every non-IDLE state.
- Err  out  1  one-cycle pulse, coincident with Over, for reserved Cycle_Type.
- CLE  out  1  command latch enable.
- ALE  out  1  address latch enable.
- WEn  out  1  write enable, active-low.
- DQ_Out  out  8  byte driven to pads.
- DQ_OE  out  1  pad output enable.

Behaviour:
- Reset, sampled at CLK edge while RST=1, overrides everything, including mid-cycle. Effects: state IDLE, counters 0, WEn=1, CLE=0, ALE=0, DQ_OE=0, DQ_Out=0x00, Over=0, Busy=0, Err=0.
- All outputs are registers loaded on the same edge that enters a state. There is no extra cycle of lag versus the state.
- States: IDLE, SETUP, WE_LOW, HOLD, OVER; one phase counter, 8 bits, cleared on every state change.
- IDLE: outputs at reset values. On Start=1, latch Cycle_Type and Din.
  - Type 00/01/10: go to SETUP.
  - Type 11: go directly to OVER with Err=1; no bus activity (WEn, CLE, ALE, DQ_OE unchanged).
- SETUP, lasting tSETUP_cnt cycles:
  - WEn=1, DQ_OE=1, DQ_Out=latched Din.
  - CLE=1 only for type 00; ALE=1 only for type 01.
- WE_LOW, lasting tWP_cnt cycles: as SETUP but WEn=0.
- HOLD, lasting tHOLD_cnt cycles: as SETUP (WEn=1; CLE/ALE/DQ unchanged).
- OVER, lasting 1 cycle: Over=1, WEn=1, CLE=0, ALE=0, DQ_OE=0, DQ_Out holds. Then IDLE.
- Timing from the edge E0 that samples Start:
  - WEn falls at E0+tSETUP_cnt and rises at E0+tSETUP_cnt+tWP_cnt.
  - Over is high at E0+tSETUP_cnt+tWP_cnt+tHOLD_cnt.
- Start, Cycle_Type and Din changes are ignored outside IDLE. Minimum Start-to-Start period is tSETUP_cnt+tWP_cnt+tHOLD_cnt+2 cycles.
- CLE and ALE are never both 1. WEn is never 0 while DQ_OE=0.

Optional Feature:
- Macro NAND_WR_BURST_EN.
- Defined:
  - Adds input Len[7:0], the byte count sampled with Start; 0 treated as 1, valid for type 10 only, ignored otherwise.
  - Adds output Din_Req[1], a one-cycle pulse on the last HOLD cycle when bytes remain.
  - The requester must present the next Din by the following edge; that edge latches Din, decrements the remaining count and returns to SETUP. CLE/ALE stay 0 and DQ_OE stays 1 between bytes.
  - OVER is entered only after the final byte's HOLD.
- Undefined: single byte per Start; no Len/Din_Req ports.

Test Plan:
- Defaults; Start, type 00, Din=0x80 → CLE=1 for 4 cycles from E0; WEn low exactly at E0+1..E0+2; DQ_Out=0x80; Over=1 at E0+4; Busy high E0..E0+4.
- Type 01, Din=0x3C, tSETUP_cnt=2, tWP_cnt=3, tHOLD_cnt=2 → ALE=1, CLE=0; WEn low E0+2..E0+4; Over at E0+7.
- Type 11 → Over and Err high together at E0+0 state OVER; WEn, CLE, ALE, DQ_OE never asserted.
- Start held high continuously with type 10 → back-to-back cycles with a 6-cycle period; Din changes mid-cycle are not reflected on DQ_Out.
- RST=1 asserted during WE_LOW → next edge WEn=1, DQ_OE=0, Busy=0, no Over; subsequent Start works normally.
- With NAND_WR_BURST_EN: Len=3, bytes 0xA1/0xA2/0xA3 → 3 WEn pulses, 2 Din_Req pulses, DQ sequence correct, single Over.
